transpose_pingpong: RTL and testbench



---
 rtl/transpose_pkg.sv | 20 ++
 rtl/transpose_bank.sv | 67 ++++++
 rtl/transpose_pingpong.sv | 144 ++++++++++++++
 tb/tb_transpose_pingpong.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_pkg.sv
// Shared types and helpers for the ping-pong transpose buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package transpose_pkg;

  // One bit selects between the two ping-pong banks.
  typedef logic bank_t;

  // Index width for N rows/columns; never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of element e inside an n-element row of w-bit elements.
  // Element 0 is the most significant element of the row.
  function automatic int elem_lsb(input int n, input int w, input int e);
    return (n - 1 - e) * w;
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One N x N bank of W-bit elements: masked row writes, combinational row/column reads.
// Latency: write lands on the clock edge; read port is purely combinational.
// Backpressure: none; the owner gates wr_en.
//
// Ports:
//   clk      clock
//   wr_en    write strobe for row wr_addr
//   wr_addr  row to write
//   wr_be_n  active-low element enables (bit e -> element e)
//   wr_data  row data, element 0 in the MS position
//   rd_idx   row or column index to read
//   rd_row   1 = return row rd_idx, 0 = return column rd_idx
//   rd_data  selected row/column, row 0 (or element 0) in the MS position
module transpose_bank
  import transpose_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  localparam int AW = calc_aw(N)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [N-1:0]   wr_be_n,
  input  logic [N*W-1:0] wr_data,
  input  logic [AW-1:0]  rd_idx,
  input  logic           rd_row,
  output logic [N*W-1:0] rd_data
);

  logic [N*W-1:0] mem_q [N];
  logic [N*W-1:0] mem_d [N];

  // Disabled elements keep their previous contents.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      mem_d[r] = mem_q[r];
    end
    if (wr_en) begin
      for (int e = 0; e < N; e++) begin
        if (!wr_be_n[e]) begin
          mem_d[wr_addr][elem_lsb(N, W, e) +: W] = wr_data[elem_lsb(N, W, e) +: W];
        end
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      mem_q[r] <= mem_d[r];
    end
  end

  // A column gathers element rd_idx from every row, row 0 landing MS.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < N; p++) begin
      if (rd_row) begin
        rd_data[elem_lsb(N, W, p) +: W] = mem_q[rd_idx][elem_lsb(N, W, p) +: W];
      end else begin
        rd_data[elem_lsb(N, W, p) +: W] = mem_q[p][elem_lsb(N, W, int'(rd_idx)) +: W];
      end
    end
  end

endmodule

// File: rtl/transpose_pingpong.sv
// Two-bank ping-pong transpose buffer: rows in, columns (or rows) out.
// Latency: commit at edge k gives the first output beat after edge k+1; one beat per cycle.
// Backpressure: wr_ready drops while the write bank is full; output holds while rd_ready is low.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_valid/wr_ready     row write handshake
//   wr_addr, wr_be_n      row index and active-low element enables
//   wr_data, wr_last      row data; wr_last commits the write bank
//   mode                  0 = column drain, 1 = row drain (sampled at beat 0)
//   rd_valid/rd_ready     output beat handshake
//   rd_data, rd_idx       beat contents and its column/row index
//   rd_last               final beat of a bank
module transpose_pingpong
  import transpose_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8,
  localparam int AW = calc_aw(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [AW-1:0]  wr_addr,
  input  logic [N-1:0]   wr_be_n,
  input  logic [N*W-1:0] wr_data,
  input  logic           wr_last,
  input  logic           mode,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [N*W-1:0] rd_data,
  output logic [AW-1:0]  rd_idx,
  output logic           rd_last
);

  logic [1:0]     full_q, full_d;
  bank_t          wb_q, wb_d;
  bank_t          rb_q, rb_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;
  logic [AW-1:0]  rd_idx_q, rd_idx_d;
  logic [N*W-1:0] rd_data_q, rd_data_d;

  logic           wr_fire;
  logic           load;
  logic           beat_last;
  logic           rd_row_sel;
  logic [N*W-1:0] bank_rd [2];

  assign wr_ready = !full_q[wb_q];
  assign wr_fire  = wr_valid & wr_ready;
  assign load     = (!rd_valid_q | rd_ready) & full_q[rb_q];
  assign beat_last = (cnt_q == AW'(N - 1));
  // Beat 0 reads with the live mode so it matches the value captured into mode_q.
  assign rd_row_sel = (cnt_q == '0) ? mode : mode_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (wr_fire & (wb_q == bank_t'(b))),
      .wr_addr (wr_addr),
      .wr_be_n (wr_be_n),
      .wr_data (wr_data),
      .rd_idx  (cnt_q),
      .rd_row  (rd_row_sel),
      .rd_data (bank_rd[b])
    );
  end

  always_comb begin
    full_d     = full_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;

    if (load) begin
      if (cnt_q == '0) begin
        mode_d = mode;
      end
      rd_data_d  = bank_rd[rb_q];
      rd_idx_d   = cnt_q;
      rd_valid_d = 1'b1;
      rd_last_d  = beat_last;
      if (beat_last) begin
        // Last beat already sits in the output register, so the bank is free now.
        cnt_d        = '0;
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    // The writer only commits a non-full bank, so this never collides with the release above.
    if (wr_fire && wr_last) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
    end else begin
      full_q     <= full_d;
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_idx   = rd_idx_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_transpose_pingpong.sv
// Bench for transpose_pingpong: reference model of two banks plus directed and random traffic.
// Latency: n/a.
// Backpressure: bench drives rd_ready both held and randomised.
module tb_transpose_pingpong;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [N-1:0]  wr_be_n = '0;
  logic [63:0]   wr_data = '0;
  logic          wr_last = 1'b0;
  logic          mode = 1'b0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [63:0]   rd_data;
  logic [AW-1:0] rd_idx;
  logic          rd_last;

  always #5 clk = ~clk;

  transpose_pingpong #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_be_n  (wr_be_n),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .mode     (mode),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_idx   (rd_idx),
    .rd_last  (rd_last)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mem [2][N][N];      // [bank][row][element]
  int          occ = 0;            // banks committed and not yet released
  int          cnt = 0;
  int          wbm = 0, rbm = 0;
  bit          bmode = 1'b0;
  bit          p_valid = 0, p_ready = 0, p_mode = 0, p_wv = 0, p_wrdy = 0, p_last = 0;
  logic [2:0]  p_addr = '0;
  logic [7:0]  p_be = '0;
  logic [63:0] p_data = '0;
  logic [63:0] h_data = '0;
  int          h_idx = 0;
  logic [63:0] log_data [$];
  int          log_idx [$];
  bit          log_last [$];

  function automatic logic [63:0] model_beat(input int b, input int i, input bit rowm);
    logic [63:0] v;
    v = '0;
    for (int p = 0; p < N; p++) v[(N-1-p)*W +: W] = rowm ? mem[b][i][p] : mem[b][p][i];
    return v;
  endfunction

  initial begin
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < N; r++)
        for (int e = 0; e < N; e++) mem[b][r][e] = 8'h00;
  end

  always @(negedge clk) begin : cmp
    bit          exp_load;
    logic [63:0] eb;
    if (!rst_n) begin
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_rd_last",  64'(rd_last),  64'd0);
      chk("rst_rd_idx",   64'(rd_idx),   64'd0);
      chk("rst_rd_data",  rd_data,       64'd0);
      chk("rst_wr_ready", 64'(wr_ready), 64'd1);
      occ = 0; cnt = 0; wbm = 0; rbm = 0;
      p_valid = 0; p_ready = 0; p_wv = 0; p_wrdy = 0; p_last = 0;
    end else begin
      exp_load = (!p_valid || p_ready) && occ > 0;
      chk("rd_valid", 64'(rd_valid), 64'(exp_load || (p_valid && !p_ready)));
      if (exp_load) begin
        if (cnt == 0) bmode = p_mode;
        eb = model_beat(rbm, cnt, bmode);
        chk("beat_data", rd_data,       eb);
        chk("beat_idx",  64'(rd_idx),   64'(cnt));
        chk("beat_last", 64'(rd_last),  64'(cnt == N-1));
        log_data.push_back(rd_data);
        log_idx.push_back(int'(rd_idx));
        log_last.push_back(rd_last);
        h_data = eb;
        h_idx  = cnt;
        if (cnt == N-1) begin
          cnt = 0; rbm = 1 - rbm; occ--;
        end else cnt++;
      end else if (p_valid && !p_ready) begin
        chk("stall_data", rd_data,     h_data);
        chk("stall_idx",  64'(rd_idx), 64'(h_idx));
      end
      if (p_wv && p_wrdy) begin
        for (int e = 0; e < N; e++)
          if (!p_be[e]) mem[wbm][p_addr][e] = p_data[(N-1-e)*W +: W];
        if (p_last) begin
          occ++; wbm = 1 - wbm;
        end
      end
      chk("wr_ready", 64'(wr_ready), 64'(occ < 2));
      p_valid = exp_load || (p_valid && !p_ready);
      p_ready = rd_ready;
      p_mode  = mode;
      p_wv    = wr_valid;
      p_wrdy  = (occ < 2);
      p_last  = wr_last;
      p_addr  = wr_addr;
      p_be    = wr_be_n;
      p_data  = wr_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] pat(input int r, input logic [7:0] x);
    logic [63:0] v;
    for (int e = 0; e < N; e++) v[(N-1-e)*W +: W] = {4'(r), 4'(e)} ^ x;
    return v;
  endfunction

  task automatic wr(input logic [2:0] a, input logic [7:0] ben, input logic [63:0] d, input bit last);
    int t;
    t = 0;
    wr_valid = 1'b1; wr_addr = a; wr_be_n = ben; wr_data = d; wr_last = last;
    @(negedge clk);
    while (!wr_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("wr_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic fill(input logic [7:0] x);
    for (int r = 0; r < N; r++) wr(3'(r), 8'h00, pat(r, x), r == N-1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic clear_log();
    log_data.delete(); log_idx.delete(); log_last.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin : stim
    int t;
    int vcount;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Full-bank column drain with rd_ready held high.
    clear_log(); rd_ready = 1'b1; mode = 1'b0;
    fill(8'h00);
    @(negedge clk); chk("t1_valid_after_commit", 64'(rd_valid), 64'd0);
    @(negedge clk); chk("t1_valid_next_cycle",   64'(rd_valid), 64'd1);
    tick(12);
    chk("t1_beat_count", 64'(log_data.size()), 64'd8);
    if (log_data.size() >= 8) begin
      chk("t1_col0", log_data[0], 64'h0010203040506070);
      for (int i = 0; i < 8; i++) begin
        chk("t1_idx",  64'(log_idx[i]),  64'(i));
        chk("t1_last", 64'(log_last[i]), 64'(i == 7));
      end
    end

    // Partial-enable rewrite of row 3 before commit.
    clear_log();
    for (int r = 0; r < N; r++) wr(3'(r), 8'h00, pat(r, 8'h00), 1'b0);
    wr(3'd3, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick(12);
    chk("t2_beat_count", 64'(log_data.size()), 64'd8);
    if (log_data.size() >= 8) begin
      chk("t2_col0", log_data[0], 64'h001020FF40506070);
      chk("t2_col4", log_data[4], 64'h0414243444546474);
    end

    // Random traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr  = 3'($urandom);
      wr_be_n  = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom);
      wr_data  = {$urandom(), $urandom()};
      wr_last  = ($urandom_range(0, 7) == 0);
      mode     = 1'($urandom);
      rd_ready = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b1;
    tick(40);
    @(negedge clk); chk("rand_drained", 64'(rd_valid), 64'd0);
    tick(1);

    // Both banks full, third write refused, then back-to-back drain.
    reset_pulse(); clear_log(); rd_ready = 1'b0; mode = 1'b0;
    fill(8'h00);
    fill(8'h88);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_be_n = 8'h00; wr_data = 64'hABAB_ABAB_ABAB_ABAB; wr_last = 1'b1;
    repeat (4) begin
      @(negedge clk); chk("t3_wr_ready_low", 64'(wr_ready), 64'd0);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0;
    rd_ready = 1'b1;
    vcount = 0;
    repeat (16) begin
      @(negedge clk);
      if (rd_valid) vcount++;
    end
    chk("t3_no_bubble", 64'(vcount), 64'd16);
    tick(4);
    chk("t3_beat_count", 64'(log_data.size()), 64'd16);
    if (log_data.size() >= 16) begin
      chk("t3_bank0_col0", log_data[0], 64'h0010203040506070);
      chk("t3_bank1_col0", log_data[8], 64'h8898A8B8C8D8E8F8);
      chk("t3_last15",     64'(log_last[15]), 64'd1);
    end

    // Row drain then column drain, with mode toggled mid-drain.
    reset_pulse(); clear_log(); rd_ready = 1'b0; mode = 1'b1;
    fill(8'h00);
    fill(8'h00);
    rd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 4) mode = ~mode;
      else if (c < 10) mode = 1'b0;
      else mode = ~mode;
      tick(1);
    end
    chk("t5_beat_count", 64'(log_data.size()), 64'd16);
    if (log_data.size() >= 16) begin
      chk("t5_row0", log_data[0],  64'h0001020304050607);
      chk("t5_row3", log_data[3],  64'h3031323334353637);
      chk("t5_col0", log_data[8],  64'h0010203040506070);
      chk("t5_col3", log_data[11], 64'h0313233343536373);
    end

    // Reset in the middle of a drain.
    clear_log(); rd_ready = 1'b1; mode = 1'b0;
    fill(8'h00);
    t = 0;
    @(negedge clk);
    while (!(rd_valid && rd_idx == 3'd4) && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (t >= 50) chk("t6_idx4_timeout", 64'd0, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_valid", 64'(rd_valid), 64'd0);
    chk("t6_rd_last",  64'(rd_last),  64'd0);
    chk("t6_rd_idx",   64'(rd_idx),   64'd0);
    chk("t6_rd_data",  rd_data,       64'd0);
    chk("t6_wr_ready", 64'(wr_ready), 64'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_log();
    tick(20);
    chk("t6_no_beats", 64'(log_data.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
